// File: rtl/input_packer.sv
// Collects NUM_INPUTS 32-bit words into one wide vector and holds it until downstream takes it.
// Optional INPUT_RELU_EN: negative input words are clamped to zero before they are stored.
module input_packer #(
   parameter int NUM_INPUTS = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [31:0]                          in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 flush,
   output logic [NUM_INPUTS*32-1:0]             out_vec,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(NUM_INPUTS+1)-1:0]      word_count
);

   localparam int CW = $clog2(NUM_INPUTS + 1);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     slot_q [NUM_INPUTS];
   logic [31:0]     slot_d [NUM_INPUTS];
   logic [31:0]     word_in;
   logic            accept;

`ifdef INPUT_RELU_EN
   assign word_in = in_data[31] ? 32'h0000_0000 : in_data;
`else
   assign word_in = in_data;
`endif

   assign in_ready   = (state_q != S_FULL);
   assign out_valid  = (state_q == S_FULL);
   assign word_count = count_q;
   assign accept     = in_valid && in_ready && !flush;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (flush) begin
         state_d = S_EMPTY;
         count_d = '0;
      end else begin
         case (state_q)
            S_EMPTY, S_FILL: begin
               if (accept) begin
                  count_d = count_q + 1'b1;
                  state_d = (count_q == CW'(NUM_INPUTS - 1)) ? S_FULL : S_FILL;
               end
            end
            S_FULL: begin
               // The release cycle never accepts: in_ready is low throughout FULL.
               if (out_ready) begin
                  state_d = S_EMPTY;
                  count_d = '0;
               end
            end
            default: begin
               state_d = S_EMPTY;
               count_d = '0;
            end
         endcase
      end
   end

   // Only the slot addressed by the current count is written; all others keep stale data.
   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slot
      assign slot_d[gi] = (accept && (count_q == CW'(gi))) ? word_in : slot_q[gi];
      assign out_vec[gi*32 +: 32] = slot_q[gi];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         count_q <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            slot_q[i] <= 32'h0000_0000;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: tb/tb_input_packer.sv
// Scoreboard bench for input_packer: a 4-word instance and a 1-word instance share clock and reset.
module tb_input_packer;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0]       a_data;
   logic              a_valid, a_flush, a_oready;
   logic              a_iready, a_ovalid;
   logic [N*32-1:0]   a_vec;
   logic [2:0]        a_cnt;

   logic [31:0]       b_data;
   logic              b_valid, b_flush, b_oready;
   logic              b_iready, b_ovalid;
   logic [31:0]       b_vec;
   logic [0:0]        b_cnt;

   input_packer #(.NUM_INPUTS(N)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_iready),
      .flush(a_flush), .out_vec(a_vec), .out_valid(a_ovalid), .out_ready(a_oready),
      .word_count(a_cnt)
   );

   input_packer #(.NUM_INPUTS(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_iready),
      .flush(b_flush), .out_vec(b_vec), .out_valid(b_ovalid), .out_ready(b_oready),
      .word_count(b_cnt)
   );

   int checks = 0;
   int failures = 0;
   logic [N*32-1:0] qa[$];
   logic [31:0]     qb[$];

   function automatic logic [31:0] ew(input logic [31:0] x);
`ifdef INPUT_RELU_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [N*32-1:0] pack4(input logic [31:0] w0, w1, w2, w3);
      return {ew(w3), ew(w2), ew(w1), ew(w0)};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: peek while a vector is held, pop on the handshake.
   always @(negedge clk) begin
      if (!rst && a_ovalid) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_vec actual=%h required=none", a_vec);
         end else begin
            chk(a_oready ? "a_vec_pop" : "a_vec_hold", 128'(a_vec), 128'(qa[0]));
            if (a_oready) void'(qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_ovalid) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_vec actual=%h required=none", b_vec);
         end else begin
            chk(b_oready ? "b_vec_pop" : "b_vec_hold", 128'(b_vec), 128'(qb[0]));
            if (b_oready) void'(qb.pop_front());
         end
      end
   end

   task automatic fill_a(input logic [31:0] w0, w1, w2, w3);
      logic [31:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) begin
         a_data  = w[i];
         a_valid = 1'b1;
         if (i == 3) qa.push_back(pack4(w0, w1, w2, w3));
         tick();
      end
      a_valid = 1'b0;
   endtask

   task automatic release_a();
      a_oready = 1'b1;
      tick();
      a_oready = 1'b0;
      chk("a_released_valid", 128'(a_ovalid), 128'(0));
      chk("a_released_count", 128'(a_cnt), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      a_data = '0; a_valid = 0; a_flush = 0; a_oready = 0;
      b_data = '0; b_valid = 0; b_flush = 0; b_oready = 0;
      tick();
      tick();
      chk("rst_a_valid", 128'(a_ovalid), 128'(0));
      chk("rst_a_count", 128'(a_cnt), 128'(0));
      chk("rst_a_vec", 128'(a_vec), 128'(0));
      rst = 1'b0;
      chk("rst_a_iready", 128'(a_iready), 128'(1));

      // Basic fill with latency check.
      for (int i = 1; i <= 4; i++) begin
         a_data  = 32'(i);
         a_valid = 1'b1;
         if (i == 4) qa.push_back(pack4(1, 2, 3, 4));
         tick();
         chk("fill_count", 128'(a_cnt), 128'(i));
         chk("fill_valid", 128'(a_ovalid), 128'(i == 4));
      end
      chk("full_iready", 128'(a_iready), 128'(0));

      // Backpressure with garbage input present, including on the release cycle.
      a_data = 32'h0000_FFFF;
      for (int i = 0; i < 10; i++) tick();
      chk("bp_count", 128'(a_cnt), 128'(4));
      release_a();
      a_valid = 1'b0;
      chk("post_release_iready", 128'(a_iready), 128'(1));

      // Flush mid-fill, then a stalled refill.
      a_valid = 1'b1;
      a_data = 32'd10; tick();
      a_data = 32'd11; tick();
      chk("pre_flush_count", 128'(a_cnt), 128'(2));
      a_flush = 1'b1; a_data = 32'd99; tick();
      a_flush = 1'b0;
      chk("flush_count", 128'(a_cnt), 128'(0));
      chk("flush_valid", 128'(a_ovalid), 128'(0));
      a_data = 32'd20; tick();
      a_data = 32'd21; tick();
      a_valid = 1'b0; a_data = 32'd77; tick(); tick();
      chk("stall_count", 128'(a_cnt), 128'(2));
      a_valid = 1'b1;
      a_data = 32'd22; tick();
      qa.push_back(pack4(20, 21, 22, 23));
      a_data = 32'd23; tick();
      a_valid = 1'b0;
      chk("refill_valid", 128'(a_ovalid), 128'(1));
      release_a();

      // Clamp behaviour depends on the build.
      fill_a(32'h8000_0005, 32'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
      chk("relu_slot0", 128'(a_vec[31:0]), 128'(ew(32'h8000_0005)));
      release_a();

      // Reset while a vector is held.
      fill_a(32'd1, 32'd2, 32'd3, 32'd4);
      chk("pre_rst_valid", 128'(a_ovalid), 128'(1));
      rst = 1'b1;
      qa.delete();
      tick();
      rst = 1'b0;
      chk("rst_full_valid", 128'(a_ovalid), 128'(0));
      chk("rst_full_vec", 128'(a_vec), 128'(0));
      chk("rst_full_iready", 128'(a_iready), 128'(1));

      // Single-word instance: direct EMPTY->FULL, then full-rate alternation.
      b_valid = 1'b1; b_data = 32'd5;
      qb.push_back(ew(32'd5));
      tick();
      chk("b_first_valid", 128'(b_ovalid), 128'(1));
      chk("b_first_iready", 128'(b_iready), 128'(0));
      b_oready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         b_data = 32'(100 + k);
         if (k % 2 == 1) qb.push_back(ew(32'(100 + k)));
         tick();
         chk("b_alt_valid", 128'(b_ovalid), 128'(k % 2 == 1));
      end
      b_valid = 1'b0;
      tick();
      b_oready = 1'b0;
      tick();

      chk("a_queue_drained", 128'(qa.size()), 128'(0));
      chk("b_queue_drained", 128'(qb.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/input_packer.md
INPUT_PACKER -- requirements
Module: input_packer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of 32-bit words packed per vector; legal range 1..64.
REQ-002 SHALL have port clk, input, 1: single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, 32: one input word, two's complement.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-007 SHALL have port flush, input, 1: abandon the partial or held vector.
REQ-008 SHALL have port out_vec, output, NUM_INPUTS*32: packed vector for the neuron layer "in" bus; word i at bits [32*i+31:32*i].
REQ-009 SHALL have port out_valid, output, 1: out_vec holds a complete vector.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes out_vec this cycle.
REQ-011 SHALL have port word_count, output, clog2(NUM_INPUTS+1): words accepted into the current vector.

Function
REQ-012 SHALL implement a three-state FSM: EMPTY (count 0), FILL (0 < count < NUM_INPUTS), FULL (vector complete).
REQ-013 SHALL drive in_ready = 1 in EMPTY and FILL and 0 in FULL, combinationally from state only.
REQ-014 SHALL accept a word only on a cycle with in_valid && in_ready && !flush; it is written to word slot word_count, and word_count then increments.
REQ-015 SHALL store the first accepted word of a vector in slot 0, the second in slot 1, and so on up to slot NUM_INPUTS-1.
REQ-016 SHALL move from EMPTY to FILL on an accept when NUM_INPUTS > 1, and from FILL to FULL on the accept of word NUM_INPUTS-1; with NUM_INPUTS = 1, EMPTY moves directly to FULL.
REQ-017 SHALL assert out_valid on the cycle after the last word is accepted (latency 1) and hold it until a release.
REQ-018 SHALL release the vector on out_valid && out_ready: next cycle out_valid = 0, word_count = 0, state EMPTY.
REQ-019 SHALL NOT accept input on the release cycle; the first word of the next vector is accepted no earlier than the cycle after release.
REQ-020 SHALL hold out_vec stable while out_valid = 1 regardless of in_valid or in_data.
REQ-021 SHALL leave unfilled and stale slots at their previous contents (not cleared); downstream uses out_vec only while out_valid = 1.
REQ-022 SHALL give flush priority over accept and release: next cycle state EMPTY, word_count = 0, out_valid = 0; in_data on the flush cycle is discarded.
REQ-023 SHALL treat in_valid toggling mid-vector as a stall only; no timeout and no loss of partial words.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, set state EMPTY, word_count 0, out_valid 0 and out_vec all zeros.
REQ-025 SHALL give rst priority over flush, accept and release, including mid-fill and while FULL.
REQ-026 SHALL drive in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL use macro INPUT_RELU_EN to control input clamping.
REQ-028 SHALL, when INPUT_RELU_EN is defined, replace any accepted word with bit 31 = 1 by 32'h0000_0000 before storing it.
REQ-029 SHALL, when INPUT_RELU_EN is undefined, store accepted words unmodified.
REQ-030 SHALL keep handshake timing and latency identical with and without INPUT_RELU_EN.

Verification
REQ-031 SHALL cover basic fill: NUM_INPUTS = 4, words 1, 2, 3, 4 on consecutive cycles with out_ready = 0 -> out_valid rises 1 cycle after word 4; out_vec = {4,3,2,1}; in_ready = 0.
REQ-032 SHALL cover backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 and data 0xFFFF -> out_vec is unchanged; out_ready = 1 -> out_valid = 0 and word_count = 0 next cycle.
REQ-033 SHALL cover flush mid-fill: accept 2 words, then flush = 1 with in_valid = 1 -> word_count = 0 next cycle; the next 4 words form a vector with the new first word in slot 0.
REQ-034 SHALL cover reset while FULL: rst = 1 with out_valid = 1 -> out_valid = 0, out_vec = 0, in_ready = 1 next cycle.
REQ-035 SHALL cover the macro: input 0x8000_0005 -> slot value 0 with INPUT_RELU_EN defined, 0x8000_0005 without it.
REQ-036 SHALL cover NUM_INPUTS = 1: a single accept -> out_valid next cycle; release and re-accept at full rate alternate every cycle.
